card_dealer: RTL and testbench

- Draws one playing-card rank on request from the game FSM.
- Uses the free-running 50 MHz count value as its random source.
- Tracks a 52-card deck: at most 4 copies of each rank are dealt.
- Optionally holds the result for a tick-counted reveal delay (2 s at 2 kHz), so the FSM gets one handshake covering both the draw and the wait.

---
 rtl/card_dealer.sv | 168 ++++++++++++++++
 tb/tb_card_dealer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: draws one card rank (1..13) per request from a 52-card deck.
// The free-running count on i_Seed is latched and reduced modulo 13 by
// repeated subtraction; if the chosen rank already has 4 copies dealt, the
// next rank (13 wraps to 1) is probed until a free copy is found.
//
// Optional feature macro: CARD_HOLD_EN
//   defined   - after a card is chosen, wait HOLD_TICKS pulses of i_Tick2K
//               before presenting it, so the requester sees one handshake
//               covering both the draw and the reveal delay.
//   undefined - the card is presented straight after the deck check;
//               HOLD_TICKS and i_Tick2K are unused.
//
// Handshake: i_Draw / i_NewDeck are sampled only while o_Busy is low (IDLE).
// A request is accepted on the clock edge where it is seen in IDLE. The
// result is announced by a single-cycle o_CardValid pulse, and o_Card /
// o_Points hold that result until the next delivery. o_DbgState exposes the
// FSM state for observation.
module card_dealer #(
    parameter int WIDTH      = 12,
    parameter int HOLD_TICKS = 4000
) (
    input  logic             clk_50M,
    input  logic             i_Reset,
    input  logic             i_Tick2K,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_Draw,
    input  logic             i_NewDeck,
    output logic             o_Busy,
    output logic             o_CardValid,
    output logic [3:0]       o_Card,
    output logic [3:0]       o_Points,
    output logic [5:0]       o_Remaining,
    output logic             o_DeckEmpty,
    output logic [2:0]       o_DbgState
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_REDUCE = 3'd2,
        S_CHECK  = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] val_q;
    logic [3:0]       rank_q;
    logic [2:0]       cnt_q [13];
    logic [5:0]       remaining_q;
    logic             valid_q;
    logic [3:0]       card_q;
    logic [3:0]       points_q;

`ifdef CARD_HOLD_EN
    localparam int HW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
    logic [HW-1:0] hold_q;
`else
    // The reveal delay is timed by the requester in this build.
    localparam int unused_hold_ticks = HOLD_TICKS;
    logic unused_tick;
    assign unused_tick = i_Tick2K;
`endif

    // Derived values for the probe in CHECK.
    logic [3:0] rank_idx_d;
    logic [2:0] cnt_sel_d;
    logic [3:0] rank_next_d;
    logic [3:0] points_d;

    // Select the count of the rank being probed and precompute the wrap and
    // the point value of that rank.
    always_comb begin
        rank_idx_d  = (rank_q == 4'd0) ? 4'd0 : rank_q - 4'd1;
        cnt_sel_d   = (rank_idx_d <= 4'd12) ? cnt_q[rank_idx_d] : 3'd4;
        rank_next_d = (rank_q >= 4'd13) ? 4'd1 : rank_q + 4'd1;
        points_d    = (rank_q >= 4'd10) ? 4'd10 : rank_q;
    end

    // Main FSM: deck bookkeeping, seed reduction, probing and delivery.
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_q     <= S_IDLE;
            val_q       <= '0;
            rank_q      <= 4'd0;
            remaining_q <= 6'd52;
            valid_q     <= 1'b0;
            card_q      <= 4'd0;
            points_q    <= 4'd0;
            for (int i = 0; i < 13; i++) cnt_q[i] <= 3'd0;
`ifdef CARD_HOLD_EN
            hold_q      <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_NewDeck) begin
                        for (int i = 0; i < 13; i++) cnt_q[i] <= 3'd0;
                        remaining_q <= 6'd52;
                    end else if (i_Draw && (remaining_q != 6'd0)) begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    val_q   <= i_Seed;
                    state_q <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (val_q >= WIDTH'(13)) begin
                        val_q <= val_q - WIDTH'(13);
                    end else begin
                        rank_q  <= val_q[3:0] + 4'd1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cnt_sel_d < 3'd4) begin
                        cnt_q[rank_idx_d] <= cnt_sel_d + 3'd1;
                        remaining_q       <= remaining_q - 6'd1;
`ifdef CARD_HOLD_EN
                        hold_q  <= '0;
                        state_q <= S_HOLD;
`else
                        state_q  <= S_DONE;
                        valid_q  <= 1'b1;
                        card_q   <= rank_q;
                        points_q <= points_d;
`endif
                    end else begin
                        rank_q <= rank_next_d;
                    end
                end
                S_HOLD: begin
`ifdef CARD_HOLD_EN
                    if (i_Tick2K) begin
                        if (hold_q >= HW'(HOLD_TICKS - 1)) begin
                            state_q  <= S_DONE;
                            valid_q  <= 1'b1;
                            card_q   <= rank_q;
                            points_q <= points_d;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Busy      = (state_q != S_IDLE);
    assign o_CardValid = valid_q;
    assign o_Card      = card_q;
    assign o_Points    = points_q;
    assign o_Remaining = remaining_q;
    assign o_DeckEmpty = (remaining_q == 6'd0);
    assign o_DbgState  = state_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a table of directed draws with
// hand-computed card, points, remaining count and latency, followed by
// hand-written sequences for deck exhaustion, refill priority, held draw,
// reset abort and (when CARD_HOLD_EN is defined) the reveal hold.
module tb_card_dealer;
    localparam int WIDTH = 12;
    localparam int HOLD  = 4;

    logic             clk_50M;
    logic             i_Reset;
    logic             i_Tick2K;
    logic [WIDTH-1:0] i_Seed;
    logic             i_Draw;
    logic             i_NewDeck;
    logic             o_Busy;
    logic             o_CardValid;
    logic [3:0]       o_Card;
    logic [3:0]       o_Points;
    logic [5:0]       o_Remaining;
    logic             o_DeckEmpty;
    logic [2:0]       o_DbgState;

    int checks   = 0;
    int failures = 0;
    logic tick_auto = 1'b1;

    card_dealer #(.WIDTH(WIDTH), .HOLD_TICKS(HOLD)) dut (
        .clk_50M    (clk_50M),
        .i_Reset    (i_Reset),
        .i_Tick2K   (i_Tick2K),
        .i_Seed     (i_Seed),
        .i_Draw     (i_Draw),
        .i_NewDeck  (i_NewDeck),
        .o_Busy     (o_Busy),
        .o_CardValid(o_CardValid),
        .o_Card     (o_Card),
        .o_Points   (o_Points),
        .o_Remaining(o_Remaining),
        .o_DeckEmpty(o_DeckEmpty),
        .o_DbgState (o_DbgState)
    );

    // Clock and watchdog.
    initial begin
        clk_50M = 1'b0;
        forever #10 clk_50M = ~clk_50M;
    end

    initial begin
        #1800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Free-running tick source: one pulse every third cycle when enabled.
    initial begin
        int ph;
        ph = 0;
        i_Tick2K = 1'b0;
        forever begin
            @(negedge clk_50M);
            if (tick_auto) i_Tick2K = (ph == 0);
            ph = (ph + 1) % 3;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Request one card and wait for its delivery. lat counts cycles from
    // the cycle the request is seen (0) to the o_CardValid cycle.
    task automatic do_draw(input int seed, output int lat, output logic got);
        @(negedge clk_50M);
        i_Seed = WIDTH'(seed);
        i_Draw = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk_50M);
            if (c == 1) i_Draw = 1'b0;
            if (o_CardValid) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
        if (!got) check("draw_timeout", 0, 1);
    endtask

    typedef struct {
        int seed;
        int card;
        int pts;
        int rem;
        int lat;
    } vec_t;

    vec_t vecs[13];
    int   m_cnt[14];
    int   o_cnt[14];

    function automatic int predict(input int seed);
        int r;
        r = (seed % 13) + 1;
        for (int k = 0; k < 13; k++) begin
            if (m_cnt[r] < 4) break;
            r = (r == 13) ? 1 : r + 1;
        end
        return r;
    endfunction

    initial begin
        int   lat;
        logic got;
        int   bad;
        int   exp_card;

        vecs[0]  = '{0,    1,  1,  51, 4};
        vecs[1]  = '{25,   13, 10, 50, 5};
        vecs[2]  = '{4095, 1,  1,  49, 319};
        vecs[3]  = '{9,    10, 10, 48, 4};
        vecs[4]  = '{0,    1,  1,  47, 4};
        vecs[5]  = '{0,    1,  1,  46, 4};
        vecs[6]  = '{0,    2,  2,  45, 5};
        vecs[7]  = '{12,   13, 10, 44, 4};
        vecs[8]  = '{12,   13, 10, 43, 4};
        vecs[9]  = '{38,   13, 10, 42, 6};
        vecs[10] = '{12,   2,  2,  41, 6};
        vecs[11] = '{11,   12, 10, 40, 4};
        vecs[12] = '{4094, 2,  2,  39, 320};

        // Reset.
        i_Reset   = 1'b1;
        i_Seed    = '0;
        i_Draw    = 1'b0;
        i_NewDeck = 1'b0;
        repeat (3) @(negedge clk_50M);
        i_Reset = 1'b0;
        @(negedge clk_50M);
        check("rst_busy", o_Busy, 0);
        check("rst_valid", o_CardValid, 0);
        check("rst_card", o_Card, 0);
        check("rst_points", o_Points, 0);
        check("rst_remaining", o_Remaining, 52);
        check("rst_empty", o_DeckEmpty, 0);

        // Directed draw table.
        for (int i = 0; i < 13; i++) begin
            do_draw(vecs[i].seed, lat, got);
            if (got) begin
                check($sformatf("vec%0d_card", i), o_Card, vecs[i].card);
                check($sformatf("vec%0d_points", i), o_Points, vecs[i].pts);
                check($sformatf("vec%0d_remaining", i), o_Remaining, vecs[i].rem);
`ifndef CARD_HOLD_EN
                check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
`endif
                @(negedge clk_50M);
                check($sformatf("vec%0d_pulse", i), o_CardValid, 0);
                check($sformatf("vec%0d_idle", i), o_Busy, 0);
                check($sformatf("vec%0d_card_hold", i), o_Card, vecs[i].card);
            end
        end

        // Refill wins over a simultaneous draw, which is dropped.
        @(negedge clk_50M);
        i_NewDeck = 1'b1;
        i_Draw    = 1'b1;
        @(negedge clk_50M);
        i_NewDeck = 1'b0;
        i_Draw    = 1'b0;
        check("newdeck_remaining", o_Remaining, 52);
        check("newdeck_drop_draw", o_Busy, 0);

        // Exhaust the deck with arbitrary seeds against the deck model.
        for (int r = 0; r < 14; r++) begin
            m_cnt[r] = 0;
            o_cnt[r] = 0;
        end
        bad = 0;
        for (int i = 0; i < 52; i++) begin
            int seed;
            seed = $urandom_range(0, 4095);
            exp_card = predict(seed);
            do_draw(seed, lat, got);
            if (got) begin
                if (o_Card != exp_card) bad++;
                if (o_Card <= 13) o_cnt[o_Card]++;
            end
            m_cnt[exp_card]++;
        end
        check("deal52_card_errors", bad, 0);
        @(negedge clk_50M);
        check("deal52_empty", o_DeckEmpty, 1);
        check("deal52_remaining", o_Remaining, 0);
        for (int r = 1; r <= 13; r++)
            check($sformatf("deal52_rank%0d_count", r), o_cnt[r], 4);

        // Draw on an empty deck is ignored.
        i_Seed = '0;
        i_Draw = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_50M);
            i_Draw = 1'b0;
            if (o_Busy || o_CardValid) bad++;
        end
        check("empty_draw_ignored", bad, 0);

        i_NewDeck = 1'b1;
        @(negedge clk_50M);
        i_NewDeck = 1'b0;
        check("refill_remaining", o_Remaining, 52);
        check("refill_empty", o_DeckEmpty, 0);

        // Draw held high across delivery starts the next draw at once.
        i_Seed = '0;
        i_Draw = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_50M);
            if (o_CardValid) begin
                got = 1'b1;
                break;
            end
        end
        check("held_first_valid", got, 1);
        @(negedge clk_50M);
        check("held_idle_cycle", o_Busy, 0);
        @(negedge clk_50M);
        check("held_restart", o_Busy, 1);
        i_Draw = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_50M);
            if (o_CardValid) begin
                got = 1'b1;
                break;
            end
        end
        check("held_second_valid", got, 1);
        check("held_second_card", o_Card, 1);
        check("held_remaining", o_Remaining, 50);

`ifdef CARD_HOLD_EN
        // Reveal hold: valid comes the cycle after the 4th tick in HOLD.
        tick_auto = 1'b0;
        @(negedge clk_50M);
        i_Tick2K = 1'b0;
        i_Seed = WIDTH'(1);
        i_Draw = 1'b1;
        @(negedge clk_50M);
        i_Draw = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (o_DbgState == 3'd4) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_50M);
        end
        check("hold_reached", got, 1);
        repeat (3) @(negedge clk_50M);
        check("hold_no_ticks", o_CardValid, 0);
        for (int k = 1; k <= 4; k++) begin
            i_Tick2K = 1'b1;
            if (k == 2) i_Draw = 1'b1;
            @(negedge clk_50M);
            i_Tick2K = 1'b0;
            i_Draw = 1'b0;
            if (k < 4) begin
                check($sformatf("hold_tick%0d_wait", k), o_CardValid, 0);
                @(negedge clk_50M);
            end else begin
                check("hold_tick4_valid", o_CardValid, 1);
                check("hold_card", o_Card, 2);
            end
        end
        @(negedge clk_50M);
        @(negedge clk_50M);
        check("hold_draw_ignored", o_Busy, 0);
        check("hold_remaining", o_Remaining, 49);
        tick_auto = 1'b1;
`endif

        // Reset aborts a draw in progress without delivering it.
        @(negedge clk_50M);
        i_Seed = WIDTH'(4095);
        i_Draw = 1'b1;
        @(negedge clk_50M);
        i_Draw = 1'b0;
        repeat (20) @(negedge clk_50M);
        check("abort_busy_before", o_Busy, 1);
        i_Reset = 1'b1;
        @(negedge clk_50M);
        i_Reset = 1'b0;
        check("abort_busy", o_Busy, 0);
        check("abort_remaining", o_Remaining, 52);
        check("abort_card", o_Card, 0);
        check("abort_points", o_Points, 0);
        check("abort_valid", o_CardValid, 0);
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_50M);
            if (o_CardValid || o_Busy) bad++;
        end
        check("abort_no_delivery", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
